// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT-80 stream accelerator: register map,
// STATUS bit positions, chaining mode and sequencer state encodings.
package present_pkg;

  localparam logic [3:0] ADDR_CTRL    = 4'd0;
  localparam logic [3:0] ADDR_KEY_HI  = 4'd1;
  localparam logic [3:0] ADDR_KEY_MID = 4'd2;
  localparam logic [3:0] ADDR_KEY_LO  = 4'd3;
  localparam logic [3:0] ADDR_IV_HI   = 4'd4;
  localparam logic [3:0] ADDR_IV_LO   = 4'd5;
  localparam logic [3:0] ADDR_DIN_HI  = 4'd6;
  localparam logic [3:0] ADDR_DIN_LO  = 4'd7;
  localparam logic [3:0] ADDR_DOUT_HI = 4'd8;
  localparam logic [3:0] ADDR_DOUT_LO = 4'd9;
  localparam logic [3:0] ADDR_STATUS  = 4'd10;

  localparam int CTRL_MODE  = 1;
  localparam int CTRL_DIR   = 2;
  localparam int CTRL_CLEAR = 3;

  localparam int ST_BUSY      = 0;
  localparam int ST_IN_EMPTY  = 1;
  localparam int ST_IN_FULL   = 2;
  localparam int ST_OUT_EMPTY = 3;
  localparam int ST_OUT_FULL  = 4;
  localparam int ST_OVF       = 5;
  localparam int ST_UNF       = 6;
  localparam int ST_CFG_ERR   = 7;
  localparam int ST_IN_COUNT  = 8;
  localparam int ST_OUT_COUNT = 16;

  typedef enum logic {ECB = 1'b0, CBC = 1'b1} mode_e;

  typedef enum logic [1:0] {IDLE, LOAD, ARM, WAIT} seq_state_e;

endpackage

// File: rtl/present_blk_fifo.sv
// 64-bit block FIFO with occupancy count and synchronous flush.
// Simultaneous push and pop are both honoured, including push while full.
module present_blk_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             iReset,
  input  logic             flush,
  input  logic             push,
  input  logic [63:0]      wdata,
  input  logic             pop,
  output logic [63:0]      rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (iReset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/present_core.sv
// Iterative PRESENT-80 block cipher, one round per cycle. control=1 decrypts;
// decryption first walks the key schedule forward to the last round key.
module present_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        control,
  input  logic [79:0] key,
  input  logic [63:0] idat,
  output logic [63:0] odat,
  output logic        done
);
  localparam logic [63:0] SBOX  = 64'h2174_8FE3_DA09_B65C;
  localparam logic [63:0] ISBOX = 64'hA970_364B_D21C_8FE5;

  typedef enum logic [1:0] {C_IDLE, C_KEXP, C_ENC, C_DEC} core_state_e;

  core_state_e cst_q, cst_d;
  logic [63:0] st_q, st_d;
  logic [79:0] k_q, k_d;
  logic [5:0]  rnd_q, rnd_d;
  logic        done_d;

  function automatic logic [63:0] s_layer(input logic [63:0] x, input logic inv);
    logic [63:0] y;
    for (int n = 0; n < 16; n++)
      y[4*n +: 4] = inv ? ISBOX[{x[4*n +: 4], 2'b00} +: 4] : SBOX[{x[4*n +: 4], 2'b00} +: 4];
    return y;
  endfunction

  // Bit i moves to 16*i mod 63; bit 63 stays put.
  function automatic logic [63:0] p_layer(input logic [63:0] x, input logic inv);
    logic [63:0] y;
    for (int i = 0; i < 63; i++) begin
      if (inv) y[i] = x[(i * 16) % 63];
      else     y[(i * 16) % 63] = x[i];
    end
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [79:0] key_upd(input logic [79:0] k, input logic [4:0] r);
    logic [79:0] t;
    t          = {k[18:0], k[79:19]};
    t[79:76]   = SBOX[{t[79:76], 2'b00} +: 4];
    t[19:15]   = t[19:15] ^ r;
    return t;
  endfunction

  function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] r);
    logic [79:0] t;
    t          = k;
    t[19:15]   = t[19:15] ^ r;
    t[79:76]   = ISBOX[{t[79:76], 2'b00} +: 4];
    return {t[60:0], t[79:61]};
  endfunction

  always_comb begin
    cst_d  = cst_q;
    st_d   = st_q;
    k_d    = k_q;
    rnd_d  = rnd_q;
    done_d = 1'b0;
    case (cst_q)
      C_KEXP: begin
        k_d = key_upd(k_q, rnd_q[4:0]);
        if (rnd_q == 6'd31) cst_d = C_DEC;
        else                rnd_d = rnd_q + 6'd1;
      end
      C_ENC: begin
        if (rnd_q == 6'd32) begin
          st_d   = st_q ^ k_q[79:16];
          done_d = 1'b1;
          cst_d  = C_IDLE;
        end else begin
          st_d  = p_layer(s_layer(st_q ^ k_q[79:16], 1'b0), 1'b0);
          k_d   = key_upd(k_q, rnd_q[4:0]);
          rnd_d = rnd_q + 6'd1;
        end
      end
      C_DEC: begin
        if (rnd_q == 6'd0) begin
          st_d   = st_q ^ k_q[79:16];
          done_d = 1'b1;
          cst_d  = C_IDLE;
        end else begin
          st_d  = s_layer(p_layer(st_q ^ k_q[79:16], 1'b1), 1'b1);
          k_d   = key_inv(k_q, rnd_q[4:0]);
          rnd_d = rnd_q - 6'd1;
        end
      end
      default: ;
    endcase
    if (load) begin
      st_d  = idat;
      k_d   = key;
      rnd_d = 6'd1;
      cst_d = control ? C_KEXP : C_ENC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cst_q <= C_IDLE;
      st_q  <= '0;
      k_q   <= '0;
      rnd_q <= '0;
      done  <= 1'b0;
    end else begin
      cst_q <= cst_d;
      st_q  <= st_d;
      k_q   <= k_d;
      rnd_q <= rnd_d;
      done  <= done_d;
    end
  end

  assign odat = st_q;

endmodule

// File: rtl/present_stream_wrapper.sv
// Register-mapped PRESENT-80 front end: input/output block FIFOs around one
// present_core, sequenced in ECB or CBC mode over a 32-bit chip-select bus.
module present_stream_wrapper
  import present_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        iReset,
  input  logic        iChipselect,
  input  logic        iWriteRead,
  input  logic [3:0]  iAddress,
  input  logic [31:0] idat,
  output logic [31:0] odat
);
  logic             wr_acc, rd_acc, clr, busy, cfg_wr, cfg_ok, din_push;
  mode_e            mode_q;
  logic             dir_q, ovf_q, unf_q, cfg_err_q;
  logic [79:0]      key_q;
  logic [63:0]      iv_q, chain_q, cur_q;
  logic [31:0]      din_hi_q, rd_data, status;
  seq_state_e       state_q, state_d;
  logic             in_push, in_pop, in_full, in_empty;
  logic             out_push, out_pop, out_full, out_empty;
  logic [CNT_W-1:0] in_count, out_count;
  logic [63:0]      in_rdata, out_rdata;
  logic             core_rst, core_load, core_done;
  logic [63:0]      core_in, core_out, result;

  assign wr_acc   = iChipselect && iWriteRead;
  assign rd_acc   = iChipselect && !iWriteRead;
  assign clr      = wr_acc && (iAddress == ADDR_CTRL) && idat[CTRL_CLEAR];
  assign busy     = (state_q != IDLE) || !in_empty;
  // A CTRL write carrying clear is a command only; it never touches mode/dir.
  assign cfg_wr   = wr_acc && (((iAddress >= ADDR_KEY_HI) && (iAddress <= ADDR_IV_LO)) ||
                               ((iAddress == ADDR_CTRL) && !idat[CTRL_CLEAR]));
  assign cfg_ok   = cfg_wr && !busy;
  assign din_push = wr_acc && (iAddress == ADDR_DIN_LO) && !clr;
  assign in_push  = din_push && !in_full;
  assign out_pop  = rd_acc && (iAddress == ADDR_DOUT_LO) && !out_empty;
  assign core_rst = iReset || clr;
  assign core_in  = (mode_q == CBC && !dir_q) ? (cur_q ^ chain_q) : cur_q;
  assign result   = (mode_q == CBC && dir_q) ? (core_out ^ chain_q) : core_out;

  // Core handshake: load is a one-cycle request; done is a one-cycle pulse
  // qualifying odat. ARM skips a cycle so a stale done is never sampled.
  always_comb begin
    state_d   = state_q;
    in_pop    = 1'b0;
    core_load = 1'b0;
    out_push  = 1'b0;
    case (state_q)
      IDLE: if (!in_empty && !out_full) begin
        in_pop  = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        core_load = 1'b1;
        state_d   = ARM;
      end
      ARM:  state_d = WAIT;
      WAIT: if (core_done) begin
        out_push = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d   = IDLE;
      in_pop    = 1'b0;
      core_load = 1'b0;
      out_push  = 1'b0;
    end
  end

  always_comb begin
    status                           = '0;
    status[ST_BUSY]                  = busy;
    status[ST_IN_EMPTY]              = in_empty;
    status[ST_IN_FULL]               = in_full;
    status[ST_OUT_EMPTY]             = out_empty;
    status[ST_OUT_FULL]              = out_full;
    status[ST_OVF]                   = ovf_q;
    status[ST_UNF]                   = unf_q;
    status[ST_CFG_ERR]               = cfg_err_q;
    status[ST_IN_COUNT +: CNT_W]     = in_count;
    status[ST_OUT_COUNT +: CNT_W]    = out_count;
  end

  always_comb begin
    rd_data = '0;
    case (iAddress)
      ADDR_CTRL:    rd_data = {29'b0, dir_q, mode_q, 1'b0};
      ADDR_DOUT_HI: rd_data = out_empty ? 32'b0 : out_rdata[63:32];
      ADDR_DOUT_LO: rd_data = out_empty ? 32'b0 : out_rdata[31:0];
      ADDR_STATUS:  rd_data = status;
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      state_q   <= IDLE;
      mode_q    <= ECB;
      dir_q     <= 1'b0;
      key_q     <= '0;
      iv_q      <= '0;
      chain_q   <= '0;
      cur_q     <= '0;
      din_hi_q  <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      cfg_err_q <= 1'b0;
      odat      <= '0;
    end else begin
      state_q <= state_d;
      if (in_pop) cur_q <= in_rdata;
      if (wr_acc && iAddress == ADDR_DIN_HI) din_hi_q <= idat;
      if (cfg_ok) begin
        case (iAddress)
          ADDR_CTRL: begin
            mode_q <= mode_e'(idat[CTRL_MODE]);
            dir_q  <= idat[CTRL_DIR];
          end
          ADDR_KEY_HI:  key_q[79:48] <= idat;
          ADDR_KEY_MID: key_q[47:16] <= idat;
          ADDR_KEY_LO:  key_q[15:0]  <= idat[15:0];
          ADDR_IV_HI:   iv_q[63:32]  <= idat;
          ADDR_IV_LO:   iv_q[31:0]   <= idat;
          default: ;
        endcase
      end

      if (clr)                                      chain_q <= iv_q;
      else if (cfg_ok && iAddress == ADDR_IV_HI)    chain_q <= {idat, iv_q[31:0]};
      else if (cfg_ok && iAddress == ADDR_IV_LO)    chain_q <= {iv_q[63:32], idat};
      else if (out_push && mode_q == CBC)           chain_q <= dir_q ? cur_q : core_out;

      if (wr_acc && iAddress == ADDR_STATUS) begin
        if (idat[ST_OVF])     ovf_q     <= 1'b0;
        if (idat[ST_UNF])     unf_q     <= 1'b0;
        if (idat[ST_CFG_ERR]) cfg_err_q <= 1'b0;
      end
      if (din_push && in_full) ovf_q <= 1'b1;
      if (rd_acc && iAddress == ADDR_DOUT_LO && out_empty) unf_q <= 1'b1;
      if (cfg_wr && busy) cfg_err_q <= 1'b1;

      if (iChipselect) odat <= iWriteRead ? 32'b0 : rd_data;
    end
  end

  present_blk_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_in_fifo (
    .clk    (clk),
    .iReset (iReset),
    .flush  (clr),
    .push   (in_push),
    .wdata  ({din_hi_q, idat}),
    .pop    (in_pop),
    .rdata  (in_rdata),
    .count  (in_count),
    .full   (in_full),
    .empty  (in_empty)
  );

  present_blk_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_out_fifo (
    .clk    (clk),
    .iReset (iReset),
    .flush  (clr),
    .push   (out_push),
    .wdata  (result),
    .pop    (out_pop),
    .rdata  (out_rdata),
    .count  (out_count),
    .full   (out_full),
    .empty  (out_empty)
  );

  present_core u_core (
    .clk     (clk),
    .reset   (core_rst),
    .load    (core_load),
    .control (dir_q),
    .key     (key_q),
    .idat    (core_in),
    .odat    (core_out),
    .done    (core_done)
  );

endmodule

// File: tb/tb_present_stream_wrapper.sv
// Directed bench for present_stream_wrapper: bus driver tasks, a reference
// PRESENT-80 encryptor, and an expected-result queue drained from DOUT.
module tb_present_stream_wrapper;
  import present_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic        clk = 1'b0;
  logic        iReset;
  logic        iChipselect;
  logic        iWriteRead;
  logic [3:0]  iAddress;
  logic [31:0] idat;
  logic [31:0] odat;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [3:0]  sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                            4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  present_stream_wrapper #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .iReset      (iReset),
    .iChipselect (iChipselect),
    .iWriteRead  (iWriteRead),
    .iAddress    (iAddress),
    .idat        (idat),
    .odat        (odat)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    iReset = 1'b1; iChipselect = 1'b0; iWriteRead = 1'b0; iAddress = '0; idat = '0;
    repeat (3) @(negedge clk);
    iReset = 1'b0;
    @(negedge clk);
  endtask

  // Reference model
  function automatic logic [63:0] ref_enc(input logic [79:0] k_in, input logic [63:0] p);
    logic [79:0] k;
    logic [63:0] s, t;
    k = k_in;
    s = p;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sb[s[4*n +: 4]];
      t = '0;
      for (int b = 0; b < 63; b++) t[(16 * b) % 63] = s[b];
      t[63] = s[63];
      s = t;
      k = {k[18:0], k[79:19]};
      k[79:76] = sb[k[79:76]];
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  // Checkers
  task automatic check64(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Bus drivers
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    iChipselect = 1'b1; iWriteRead = 1'b1; iAddress = a; idat = d;
    @(negedge clk);
    iChipselect = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    iChipselect = 1'b1; iWriteRead = 1'b0; iAddress = a;
    @(negedge clk);
    iChipselect = 1'b0;
    d = odat;
  endtask

  task automatic push_block(input logic [63:0] blk, input logic expect_out, input logic [63:0] res);
    bus_write(ADDR_DIN_HI, blk[63:32]);
    bus_write(ADDR_DIN_LO, blk[31:0]);
    if (expect_out) exp_q.push_back(res);
  endtask

  task automatic set_key(input logic [79:0] k);
    bus_write(ADDR_KEY_HI, k[79:48]);
    bus_write(ADDR_KEY_MID, k[47:16]);
    bus_write(ADDR_KEY_LO, {16'b0, k[15:0]});
  endtask

  task automatic set_iv(input logic [63:0] v);
    bus_write(ADDR_IV_HI, v[63:32]);
    bus_write(ADDR_IV_LO, v[31:0]);
  endtask

  task automatic status_is(input string tag, input logic [31:0] exp);
    logic [31:0] s;
    bus_read(ADDR_STATUS, s);
    check32(tag, s, exp);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    int n = 0;
    bus_read(ADDR_STATUS, s);
    while (s[ST_BUSY] && n < 400) begin
      bus_read(ADDR_STATUS, s);
      n++;
    end
    check32({tag, "_idle"}, 32'(s[ST_BUSY]), 32'd0);
  endtask

  task automatic wait_out(input string tag, input int cnt);
    logic [31:0] s;
    int n = 0;
    bus_read(ADDR_STATUS, s);
    while (int'(s[ST_OUT_COUNT +: CNT_W]) != cnt && n < 400) begin
      bus_read(ADDR_STATUS, s);
      n++;
    end
    check32({tag, "_outcnt"}, 32'(s[ST_OUT_COUNT +: CNT_W]), 32'(cnt));
  endtask

  // Scoreboard
  task automatic drain_one(input string tag);
    logic [31:0] hi, lo;
    logic [63:0] e;
    bus_read(ADDR_DOUT_HI, hi);
    bus_read(ADDR_DOUT_LO, lo);
    check32({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'd0;
    check64(tag, {hi, lo}, e);
  endtask

  initial begin
    logic [31:0] d;
    logic [63:0] c1, c2, iv, p;
    logic [63:0] blk [DEPTH+2];

    do_reset();
    check32("reset_odat", odat, 32'd0);
    status_is("reset_status", 32'h0000_000A);
    repeat (3) @(negedge clk);
    check32("odat_hold", odat, 32'h0000_000A);
    bus_read(ADDR_CTRL, d);
    check32("reset_ctrl", d, 32'd0);
    bus_write(ADDR_STATUS, 32'd0);
    check32("odat_wr_clear", odat, 32'd0);

    // ECB encrypt, key 0
    bus_write(ADDR_CTRL, 32'h0);
    push_block(64'h0, 1'b1, 64'h5579C138_7B228445);
    wait_idle("ecb_k0");
    status_is("ecb_k0_outone", 32'h0001_0002);
    drain_one("ecb_k0");
    status_is("ecb_k0_idle", 32'h0000_000A);

    // ECB key all-F, encrypt then decrypt
    set_key(80'hFFFF_FFFF_FFFF_FFFF_FFFF);
    push_block(64'h0, 1'b1, 64'hE72C46C0_F5945049);
    wait_idle("ecb_kf_enc");
    drain_one("ecb_kf_enc");
    bus_write(ADDR_CTRL, 32'h4);
    bus_read(ADDR_CTRL, d);
    check32("ctrl_dir", d, 32'h4);
    push_block(64'hE72C46C0_F5945049, 1'b1, 64'h0);
    wait_idle("ecb_kf_dec");
    drain_one("ecb_kf_dec");

    // CBC encrypt then decrypt, IV 0
    set_key(80'h0);
    set_iv(64'h0);
    bus_write(ADDR_CTRL, 32'h2);
    c1 = 64'h5579C138_7B228445;
    c2 = ref_enc(80'h0, c1);
    push_block(64'h0, 1'b1, c1);
    push_block(64'h0, 1'b1, c2);
    wait_idle("cbc_enc");
    drain_one("cbc_enc_b0");
    drain_one("cbc_enc_b1");
    bus_write(ADDR_CTRL, 32'h6);
    set_iv(64'h0);
    push_block(c1, 1'b1, 64'h0);
    push_block(c2, 1'b1, 64'h0);
    wait_idle("cbc_dec");
    drain_one("cbc_dec_b0");
    drain_one("cbc_dec_b1");

    // Overflow: DEPTH+2 pushes without draining; last one is dropped
    bus_write(ADDR_CTRL, 32'h0);
    for (int i = 0; i < DEPTH + 2; i++) begin
      blk[i] = {$urandom(), $urandom()};
      push_block(blk[i], i <= DEPTH, ref_enc(80'h0, blk[i]));
    end
    bus_read(ADDR_STATUS, d);
    check32("ovf_in_full", 32'(d[ST_IN_FULL]), 32'd1);
    check32("ovf_flag", 32'(d[ST_OVF]), 32'd1);
    wait_out("ovf_stall", DEPTH);
    repeat (20) @(negedge clk);
    status_is("ovf_stall_status", 32'h0004_0131);
    drain_one("ovf_r0");
    wait_idle("ovf_resume");
    for (int i = 1; i <= DEPTH; i++) drain_one("ovf_rn");
    bus_write(ADDR_STATUS, 32'h20);
    status_is("ovf_cleared", 32'h0000_000A);

    // Underflow
    bus_read(ADDR_DOUT_LO, d);
    check32("unf_data", d, 32'd0);
    status_is("unf_set", 32'h0000_004A);
    bus_read(ADDR_DOUT_HI, d);
    check32("unf_peek", d, 32'd0);
    bus_write(ADDR_STATUS, 32'h40);
    status_is("unf_cleared", 32'h0000_000A);

    // KEY write while busy is ignored
    p = {$urandom(), $urandom()};
    push_block(p, 1'b1, ref_enc(80'h0, p));
    bus_write(ADDR_KEY_HI, 32'hFFFF_FFFF);
    bus_read(ADDR_STATUS, d);
    check32("cfg_err_set", 32'(d[ST_CFG_ERR]), 32'd1);
    wait_idle("cfg_busy");
    drain_one("cfg_oldkey");
    bus_write(ADDR_STATUS, 32'h80);
    status_is("cfg_cleared", 32'h0000_000A);

    // Clear during WAIT reloads chain from IV
    iv = {$urandom(), $urandom()};
    set_iv(iv);
    bus_write(ADDR_CTRL, 32'h2);
    p = {$urandom(), $urandom()};
    push_block(p, 1'b1, ref_enc(80'h0, p ^ iv));
    wait_idle("clr_pre");
    drain_one("clr_pre");
    p = {$urandom(), $urandom()};
    push_block(p, 1'b0, 64'h0);
    repeat (10) @(negedge clk);
    bus_write(ADDR_CTRL, 32'hA);
    status_is("clr_status", 32'h0000_000A);
    bus_read(ADDR_CTRL, d);
    check32("clr_mode_kept", d, 32'h2);
    p = {$urandom(), $urandom()};
    push_block(p, 1'b1, ref_enc(80'h0, p ^ iv));
    wait_idle("clr_post");
    drain_one("clr_chain_iv");

    check32("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/present_stream_wrapper.md
# present_stream_wrapper

Register-mapped PRESENT-80 accelerator front end: the parametrised successor to the single-block PRESENT bus wrapper. It queues plaintext or ciphertext blocks in an input FIFO and sequences them through one unmodified `present_core` in ECB or CBC mode. Results land in an output FIFO and are drained over the same 32-bit chip-select bus. Status, overflow and underflow flags are exposed to software.

## Interface
- `DEPTH`, 4: entries per FIFO; power of two, 2..16.
- `CNT_W`, $clog2(DEPTH)+1: FIFO occupancy width.
- `clk`  in  1  single clock, rising edge.
- `iReset`  in  1  synchronous, active-high reset.
- `iChipselect`  in  1  bus access this cycle.
- `iWriteRead`  in  1  1 = write, 0 = read.
- `iAddress`  in  4  word address.
- `idat`  in  32  write data.
- `odat`  out  32  registered read data; reset 0.

## Operation
- Register map:
  - 0 CTRL: [1] mode (0 ECB, 1 CBC), [2] dir (0 enc, 1 dec), [3] clear (self-clearing). Reads return {29'b0, dir, mode, 1'b0}.
  - 1/2/3 KEY[79:48]/[47:16]/[15:0] (idat[15:0]).
  - 4/5 IV[63:32]/[31:0].
  - 6 DIN_HI stage; 7 DIN_LO write pushes {stage, idat}.
  - 8 DOUT_HI peek; 9 DOUT_LO read returns low word and pops.
  - 10 STATUS: [0] busy, [1] in_empty, [2] in_full, [3] out_empty, [4] out_full, [5] ovf, [6] unf, [7] cfg_err, [8+:CNT_W] in_count, [16+:CNT_W] out_count. Write 1 to [7:5] clears those flags.
  - Other addresses: writes ignored, reads 0.
- busy = sequencer not IDLE or in FIFO non-empty.
- KEY, IV or CTRL mode/dir writes while busy: ignored, cfg_err set.
- An IV write also loads `chain`.
- Push when in FIFO full: dropped, ovf set. DOUT_LO read when out FIFO empty: returns 0, no pop, unf set. DOUT_HI read when empty returns 0.
- Sequencer FSM:
  - IDLE: if in FIFO non-empty and out_count < DEPTH, pop into `cur`, then go to LOAD. Core input = cur^chain for CBC enc, else cur.
  - LOAD: `load`=1 for one cycle, then ARM.
  - ARM: one cycle; `done` ignored; then WAIT.
  - WAIT: on `done`=1, form the result: core odat^chain for CBC dec, else core odat. Push the result.
    - Chain update: CBC enc sets chain to core odat; CBC dec sets chain to cur.
    - Then return to IDLE.
- Core `control` = dir; core `key` = KEY register.
- Clear (CTRL[3]=1 write, any state): both FIFOs emptied, FSM to IDLE, chain reloads from IV, core `reset` pulsed one cycle. KEY, IV, mode and flags are kept.
- iReset: all registers 0, FIFOs empty, FSM IDLE, core reset held.

## Timing
- Bus read data appears on odat the cycle after the access. odat holds its value when iChipselect=0 and is cleared by a write access.
- A DIN_LO write is visible in in_count the next cycle.
- Block throughput: pop to push is 3 + Tcore cycles, with Tcore the core's done latency. The next pop follows in the cycle after the push.
- Out FIFO space is checked at pop and only the sequencer pushes, so a result push never overflows.
- Same-cycle FIFO push and pop: both happen and the count is unchanged. A pop of the last entry with a simultaneous push is legal.
- Clear in the same cycle as a DIN_LO write: clear wins and the block is dropped.

## Structure
- Shared package `present_pkg` holds:
  - the register address constants;
  - STATUS bit indices;
  - a `mode_e` {ECB, CBC} typedef;
  - an FSM state typedef {IDLE, LOAD, ARM, WAIT}.
- Sub-module `present_blk_fifo`: 64-bit × DEPTH synchronous FIFO with count, full, empty and flush. Instantiated twice.
- `present_core` is instantiated unchanged.

## Test plan
- ECB enc, key 0, push 0 → DOUT 5579C138_7B228445; STATUS busy returns to 0.
- ECB enc, key all-F, push 0 → E72C46C0_F5945049. Then dir=1 and push that ciphertext → 0.
- CBC enc, IV=0, key 0, push two zero blocks → first result 5579C1387B228445, second = E(key 0, 5579C1387B228445). CBC dec of both with IV=0 → two zero blocks.
- Push DEPTH+2 blocks without draining → in_full and ovf set; out FIFO holds DEPTH results; sequencer stalls in IDLE until a DOUT_LO pop.
- Read DOUT_LO with out FIFO empty → 0 and unf set. Write 1 to STATUS[6] → unf cleared.
- Clear asserted during WAIT → counts 0, busy 0, chain=IV. A KEY write while busy → ignored and cfg_err set.
